i2c_rtc_responder: RTL

//   I2C target (responder) that emulates a DS1307-style byte register file on the SDA/SCL bus.
//   It pairs with the I2C master controller and lets that controller's write and read sequences
//   be run in simulation or looped back on-chip without a real RTC part.
//   It also exposes a local read port and a write-notify strobe for on-chip logic.

---
 rtl/i2c_rtc_responder.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/i2c_rtc_responder.sv
// I2C target emulating a DS1307-style byte register file on SDA/SCL, with a
// combinational local read port and a one-clk write-notify strobe.
module i2c_rtc_responder #(
  parameter logic [6:0] DEV_ADDR = 7'b1101000,
  parameter int         AW       = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          scl_i,
  input  logic          sda_i,
  output logic          sda_pull,
  output logic          busy,
  output logic          wr_tick,
  output logic [AW-1:0] wr_addr,
  output logic [7:0]    wr_data,
  input  logic [AW-1:0] loc_addr,
  output logic [7:0]    loc_rdata
);
  localparam int NREGS = 2**AW;

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, WAIT
  } state_t;

  // [1:0] synchronizer, [2] history
  logic [2:0] scl_pipe, sda_pipe;
  logic       scl, sda, scl_h, sda_h;
  logic       scl_rise, scl_fall, bus_start, bus_stop;

  state_t                state;
  logic [3:0]            bcnt;
  logic [7:0]            sr;
  logic [7:0]            rx_byte;
  logic                  rw;
  logic [AW-1:0]         ptr, ptr_inc;
  logic [NREGS-1:0][7:0] regs;

  assign scl       = scl_pipe[1];
  assign scl_h     = scl_pipe[2];
  assign sda       = sda_pipe[1];
  assign sda_h     = sda_pipe[2];
  assign scl_rise  = scl & ~scl_h;
  assign scl_fall  = ~scl & scl_h;
  assign bus_start = scl & scl_h & sda_h & ~sda;
  assign bus_stop  = scl & scl_h & ~sda_h & sda;

  assign rx_byte   = {sr[6:0], sda};
  assign ptr_inc   = ptr + AW'(1);
  assign loc_rdata = regs[loc_addr];

  // bcnt counts SCL rising edges within a byte; in the ACK states 8 means the
  // ACK is not yet driven and 9 means the 9th pulse is under way.
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_pipe <= '1;
      sda_pipe <= '1;
      state    <= IDLE;
      bcnt     <= '0;
      sr       <= '0;
      rw       <= 1'b0;
      ptr      <= '0;
      regs     <= '0;
      sda_pull <= 1'b0;
      busy     <= 1'b0;
      wr_tick  <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
    end else begin
      scl_pipe <= {scl_pipe[1:0], scl_i};
      sda_pipe <= {sda_pipe[1:0], sda_i};
      wr_tick  <= 1'b0;
      if (bus_start) begin
        state    <= ADDR;
        bcnt     <= '0;
        sda_pull <= 1'b0;
        busy     <= 1'b0;
      end else if (bus_stop) begin
        state    <= IDLE;
        bcnt     <= '0;
        sda_pull <= 1'b0;
        busy     <= 1'b0;
      end else begin
        case (state)
          ADDR, PTR, WDATA: begin
            if (scl_rise) begin
              sr   <= rx_byte;
              bcnt <= bcnt + 4'd1;
              if (bcnt == 4'd7) begin
                case (state)
                  ADDR: begin
                    if (rx_byte[7:1] == DEV_ADDR) begin
                      state <= ADDR_ACK;
                      busy  <= 1'b1;
                      rw    <= rx_byte[0];
                    end else begin
                      state <= WAIT;
                    end
                  end
                  PTR: begin
                    ptr   <= rx_byte[AW-1:0];
                    state <= PTR_ACK;
                  end
                  default: begin
                    regs[ptr] <= rx_byte;
                    wr_tick   <= 1'b1;
                    wr_addr   <= ptr;
                    wr_data   <= rx_byte;
                    ptr       <= ptr_inc;
                    state     <= WDATA_ACK;
                  end
                endcase
              end
            end
          end
          ADDR_ACK, PTR_ACK, WDATA_ACK: begin
            if (scl_fall) begin
              if (bcnt == 4'd8) begin
                sda_pull <= 1'b1;
                bcnt     <= 4'd9;
              end else begin
                bcnt     <= '0;
                sda_pull <= 1'b0;
                if (state == ADDR_ACK && rw) begin
                  state    <= RDATA;
                  sr       <= regs[ptr];
                  sda_pull <= ~regs[ptr][7];
                end else if (state == ADDR_ACK) begin
                  state <= PTR;
                end else begin
                  state <= WDATA;
                end
              end
            end
          end
          RDATA: begin
            if (scl_rise) begin
              bcnt <= bcnt + 4'd1;
            end else if (scl_fall) begin
              if (bcnt == 4'd8) begin
                sda_pull <= 1'b0;
                state    <= RDATA_ACK;
              end else begin
                sda_pull <= ~sr[3'd7 - bcnt[2:0]];
              end
            end
          end
          RDATA_ACK: begin
            if (scl_rise) begin
              if (!sda) begin
                ptr  <= ptr_inc;
                bcnt <= 4'd9;
              end else begin
                state <= WAIT;
                busy  <= 1'b0;
              end
            end else if (scl_fall && bcnt == 4'd9) begin
              // master ACKed: next byte goes out from the advanced pointer
              state    <= RDATA;
              bcnt     <= '0;
              sr       <= regs[ptr];
              sda_pull <= ~regs[ptr][7];
            end
          end
          IDLE, WAIT: ;
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule
